// File: rtl/bcp_clause_engine.sv
// -----------------------------------------------------------------------------
// bcp_clause_engine
//
// Evaluates clauses for Boolean constraint propagation. Clause indices from the
// control block are queued in order. For each index the engine fetches the
// clause from the clause database and reads the value of each literal's
// variable. It then classifies the clause:
//   satisfied   - some literal is true: nothing to do
//   unit        - no true literal, exactly one unassigned: push an implication
//   conflicting - every literal false (or no valid literal): raise conflict
//
// Literal layout inside cdb_data: slot 0 in the least significant bits,
// each slot = {valid, polarity, var[`MAX_VARS_BITS-1:0]}.
//
// Optional feature macro: BCP_EARLY_EXIT_EN
//   defined   - the first true literal ends evaluation; later slots are not read
//   undefined - every valid slot is read and the resolve step decides
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   bcp_en/bcp_clause_idx enqueue a clause index
//   reset_bcp             synchronous clear of conflict, overflow, queue, FSM
//   bcp_busy              work queued or in flight (never high with conflict)
//   conflict              sticky, a clause evaluated all-false
//   bcp_overflow          sticky, an index arrived while the queue was full
//   read_cdb/cdb_idx      clause DB read; cdb_data valid one cycle later
//   read_vs_bcp/var_vs_bcp var state read; val/unassign valid one cycle later
//   full_imply            imply queue cannot accept
//   push_imply, var_in_imply, val_in_imply, type_in_imply  implication out
// -----------------------------------------------------------------------------
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module bcp_clause_engine #(
    parameter int MAX_LITS       = 3,
    parameter int IDX_FIFO_DEPTH = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      bcp_en,
    input  logic [`MAX_CLAUSES_BITS-1:0]              bcp_clause_idx,
    input  logic                                      reset_bcp,
    output logic                                      bcp_busy,
    output logic                                      conflict,
    output logic                                      bcp_overflow,
    output logic                                      read_cdb,
    output logic [`MAX_CLAUSES_BITS-1:0]              cdb_idx,
    input  logic [MAX_LITS*(`MAX_VARS_BITS+2)-1:0]    cdb_data,
    output logic                                      read_vs_bcp,
    output logic [`MAX_VARS_BITS-1:0]                 var_vs_bcp,
    input  logic                                      val_vs_bcp,
    input  logic                                      unassign_vs_bcp,
    input  logic                                      full_imply,
    output logic                                      push_imply,
    output logic [`MAX_VARS_BITS-1:0]                 var_in_imply,
    output logic                                      val_in_imply,
    output logic                                      type_in_imply
);

    localparam int VW = `MAX_VARS_BITS;
    localparam int CW = `MAX_CLAUSES_BITS;
    localparam int LW = VW + 2;
    localparam int KW = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;
    localparam int PW = (IDX_FIFO_DEPTH > 1) ? $clog2(IDX_FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_LIT_RD,
        S_LIT_EV,
        S_RESOLVE,
        S_PUSH
    } state_t;

    state_t state_q, state_d;

    logic [PW:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             fifo_mem [IDX_FIFO_DEPTH];
    logic                      fifo_empty, fifo_full;
    logic [CW-1:0]             cdb_idx_q;
    logic [MAX_LITS*LW-1:0]    clause_q;
    logic [KW-1:0]             k_q;
    logic                      sat_q;
    logic [1:0]                ucnt_q;
    logic [VW-1:0]             rec_var_q;
    logic                      rec_pol_q;
    logic                      conflict_q, overflow_q;

    logic [LW-1:0]             cur_lit;
    logic [KW:0]               nxt_slot;
    logic                      lit_true;
    logic                      do_pop, do_load, do_eval, do_conflict;
    logic                      do_enq, do_ovf;

    // Lowest valid slot at or above 'start'; MSB of the result flags "found".
    // Invalid slots are skipped here, so they cost no cycles.
    function automatic logic [KW:0] find_next(input logic [MAX_LITS*LW-1:0] cl,
                                              input int                     start);
        logic [KW:0] r;
        r = '0;
        for (int i = MAX_LITS - 1; i >= 0; i--) begin
            if (cl[i*LW + LW - 1] && (i >= start)) begin
                r = {1'b1, KW'(i)};
            end
        end
        return r;
    endfunction

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // Once a conflict is flagged new indices are ignored entirely.
    assign do_enq = bcp_en && !reset_bcp && !conflict_q && !fifo_full;
    assign do_ovf = bcp_en && !reset_bcp && !conflict_q &&  fifo_full;

    always_comb begin
        cur_lit = '0;
        for (int i = 0; i < MAX_LITS; i++) begin
            if (k_q == KW'(i)) begin
                cur_lit = clause_q[i*LW +: LW];
            end
        end
    end

    assign lit_true = !unassign_vs_bcp && (val_vs_bcp == cur_lit[VW]);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes
    always_comb begin
        state_d     = state_q;
        do_pop      = 1'b0;
        do_load     = 1'b0;
        do_eval     = 1'b0;
        do_conflict = 1'b0;
        nxt_slot    = '0;
        read_cdb    = 1'b0;
        read_vs_bcp = 1'b0;
        push_imply  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !conflict_q) begin
                    do_pop  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                read_cdb = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                do_load  = 1'b1;
                nxt_slot = find_next(cdb_data, 0);
                state_d  = nxt_slot[KW] ? S_LIT_RD : S_RESOLVE;
            end
            S_LIT_RD: begin
                read_vs_bcp = 1'b1;
                state_d     = S_LIT_EV;
            end
            S_LIT_EV: begin
                do_eval  = 1'b1;
                nxt_slot = find_next(clause_q, int'(k_q) + 1);
`ifdef BCP_EARLY_EXIT_EN
                if (lit_true) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = nxt_slot[KW] ? S_LIT_RD : S_RESOLVE;
                end
`else
                state_d = nxt_slot[KW] ? S_LIT_RD : S_RESOLVE;
`endif
            end
            S_RESOLVE: begin
                if (sat_q) begin
                    state_d = S_IDLE;
                end else if (ucnt_q == 2'd0) begin
                    do_conflict = 1'b1;
                    state_d     = S_IDLE;
                end else if (ucnt_q == 2'd1) begin
                    state_d = S_PUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUSH: begin
                push_imply = 1'b1;
                if (!full_imply) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // reset_bcp wins over everything in flight
        if (reset_bcp) begin
            state_d     = S_IDLE;
            do_pop      = 1'b0;
            do_conflict = 1'b0;
        end
    end

    // Queue storage holds data only; emptiness lives in the pointers.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= bcp_clause_idx;
        end
    end

    // Queue pointers, sticky flags and clause evaluation state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            conflict_q <= 1'b0;
            overflow_q <= 1'b0;
            cdb_idx_q  <= '0;
            clause_q   <= '0;
            k_q        <= '0;
            sat_q      <= 1'b0;
            ucnt_q     <= '0;
            rec_var_q  <= '0;
            rec_pol_q  <= 1'b0;
        end else begin
            // A conflict makes the remaining queued work meaningless: flush it.
            if (reset_bcp || do_conflict) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_enq) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
                if (do_pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
            if (reset_bcp) begin
                conflict_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (do_conflict) conflict_q <= 1'b1;
                if (do_ovf)      overflow_q <= 1'b1;
            end
            if (do_pop) begin
                cdb_idx_q <= fifo_mem[rd_ptr_q[PW-1:0]];
            end
            if (do_load) begin
                clause_q <= cdb_data;
                k_q      <= nxt_slot[KW-1:0];
                sat_q    <= 1'b0;
                ucnt_q   <= '0;
            end
            if (do_eval) begin
                if (nxt_slot[KW]) begin
                    k_q <= nxt_slot[KW-1:0];
                end
                if (unassign_vs_bcp) begin
                    // Only the count 0/1/many matters, so saturate at 2.
                    if (ucnt_q != 2'd2) ucnt_q <= ucnt_q + 2'd1;
                    if (ucnt_q == 2'd0) begin
                        rec_var_q <= cur_lit[VW-1:0];
                        rec_pol_q <= cur_lit[VW];
                    end
                end else if (lit_true) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign conflict      = conflict_q;
    assign bcp_overflow  = overflow_q;
    assign bcp_busy      = !conflict_q && (bcp_en || !fifo_empty || (state_q != S_IDLE));
    assign cdb_idx       = cdb_idx_q;
    assign var_vs_bcp    = cur_lit[VW-1:0];
    assign var_in_imply  = rec_var_q;
    assign val_in_imply  = rec_pol_q;
    assign type_in_imply = push_imply;

endmodule

// File: tb/tb_bcp_clause_engine.sv
// -----------------------------------------------------------------------------
// tb_bcp_clause_engine
//
// Directed bench for bcp_clause_engine. Behavioural clause DB and var state
// table answer one cycle after their read strobes. A negedge monitor counts
// strobes, records fetch order, push latency and accepted implications.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module tb_bcp_clause_engine;

    localparam int VW = `MAX_VARS_BITS;
    localparam int CW = `MAX_CLAUSES_BITS;
    localparam int ML = 3;
    localparam int LW = VW + 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              bcp_en = 1'b0;
    logic [CW-1:0]     bcp_clause_idx = '0;
    logic              reset_bcp = 1'b0;
    logic              bcp_busy, conflict, bcp_overflow;
    logic              read_cdb;
    logic [CW-1:0]     cdb_idx;
    logic [ML*LW-1:0]  cdb_data = '0;
    logic              read_vs_bcp;
    logic [VW-1:0]     var_vs_bcp;
    logic              val_vs_bcp = 1'b0;
    logic              unassign_vs_bcp = 1'b0;
    logic              full_imply = 1'b0;
    logic              push_imply;
    logic [VW-1:0]     var_in_imply;
    logic              val_in_imply, type_in_imply;

    bcp_clause_engine #(.MAX_LITS(ML), .IDX_FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .bcp_en(bcp_en), .bcp_clause_idx(bcp_clause_idx), .reset_bcp(reset_bcp),
        .bcp_busy(bcp_busy), .conflict(conflict), .bcp_overflow(bcp_overflow),
        .read_cdb(read_cdb), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
        .read_vs_bcp(read_vs_bcp), .var_vs_bcp(var_vs_bcp),
        .val_vs_bcp(val_vs_bcp), .unassign_vs_bcp(unassign_vs_bcp),
        .full_imply(full_imply), .push_imply(push_imply),
        .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
        .type_in_imply(type_in_imply)
    );

    always #5 clock = ~clock;

    // Memory models
    logic [ML*LW-1:0] cdb_mem [0:(1<<CW)-1];
    logic             vs_val  [0:(1<<VW)-1];
    logic             vs_un   [0:(1<<VW)-1];

    always @(posedge clock) begin
        if (read_cdb)    cdb_data <= cdb_mem[cdb_idx];
        if (read_vs_bcp) begin
            val_vs_bcp      <= vs_val[var_vs_bcp];
            unassign_vs_bcp <= vs_un[var_vs_bcp];
        end
    end

    // Monitor
    int cyc = 0;
    int cdb_cnt = 0, vs_cnt = 0, push_cnt = 0, push_hi = 0, unstable = 0;
    int pop_cyc = 0, lat = 0;
    int rd_seq [0:63];
    logic          push_prev = 1'b0;
    logic [VW-1:0] pv = '0;
    logic          pval = 1'b0;
    int last_var = 0, last_val = 0, last_type = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (read_cdb === 1'b1) begin
            rd_seq[cdb_cnt & 63] = int'(cdb_idx);
            cdb_cnt++;
            pop_cyc = cyc;
        end
        if (read_vs_bcp === 1'b1) vs_cnt++;
        if (push_imply === 1'b1) begin
            push_hi++;
            if (!push_prev) begin
                lat  = cyc - pop_cyc;
                pv   = var_in_imply;
                pval = val_in_imply;
            end else if (var_in_imply !== pv || val_in_imply !== pval) begin
                unstable++;
            end
            if (!full_imply) begin
                push_cnt++;
                last_var  = int'(var_in_imply);
                last_val  = int'(val_in_imply);
                last_type = int'(type_in_imply);
            end
        end
        push_prev = (push_imply === 1'b1);
    end

    int checks = 0, errors = 0;
    int s_cdb, s_vs, s_push, s_hi, s_unst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_cdb = cdb_cnt; s_vs = vs_cnt; s_push = push_cnt; s_hi = push_hi; s_unst = unstable;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic enq(input int idx);
        bcp_en = 1'b1;
        bcp_clause_idx = CW'(idx);
        tick();
        bcp_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (bcp_busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return push_imply;
            1:       return read_vs_bcp;
            default: return conflict;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (sel(which) !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [LW-1:0] mk(input logic v, input logic p, input int var_n);
        return {v, p, VW'(var_n)};
    endfunction

    task automatic pulse_reset_bcp();
        reset_bcp = 1'b1;
        tick();
        reset_bcp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_vs;
        for (int i = 0; i < (1 << CW); i++) cdb_mem[i] = '0;
        for (int i = 0; i < (1 << VW); i++) begin vs_val[i] = 1'b0; vs_un[i] = 1'b0; end
        vs_val[1] = 1'b0; vs_un[1] = 1'b0;
        vs_val[2] = 1'b1; vs_un[2] = 1'b0;
        vs_un[3]  = 1'b1;
        vs_val[4] = 1'b0; vs_val[5] = 1'b1; vs_val[6] = 1'b0;
        vs_val[7] = 1'b1; vs_val[8] = 1'b1; vs_un[9] = 1'b1;
        cdb_mem[1] = {mk(1, 1, 3), mk(1, 0, 2), mk(1, 1, 1)};
        cdb_mem[2] = {mk(1, 1, 6), mk(1, 0, 5), mk(1, 1, 4)};
        cdb_mem[3] = {mk(1, 1, 9), mk(1, 0, 8), mk(1, 1, 7)};
        cdb_mem[5] = '0;
        cdb_mem[6] = {mk(1, 1, 3), mk(0, 0, 2), mk(1, 1, 1)};
        for (int i = 8; i <= 12; i++) cdb_mem[i] = cdb_mem[3];

        // Reset state
        @(negedge clock);
        chk("rst_busy", 32'(bcp_busy), 0);
        chk("rst_conflict", 32'(conflict), 0);
        chk("rst_overflow", 32'(bcp_overflow), 0);
        chk("rst_read_cdb", 32'(read_cdb), 0);
        chk("rst_push", 32'(push_imply), 0);
        tick();
        reset = 1'b1;
        tick();

        // Unit clause: one implication x3=1, nine cycles after the fetch
        snap();
        enq(1);
        wait_idle("unit_done", 40);
        chk("unit_push_cnt", 32'(push_cnt - s_push), 1);
        chk("unit_var", 32'(last_var), 3);
        chk("unit_val", 32'(last_val), 1);
        chk("unit_type", 32'(last_type), 1);
        chk("unit_latency", 32'(lat), 9);
        chk("unit_vs_reads", 32'(vs_cnt - s_vs), 3);
        chk("unit_conflict", 32'(conflict), 0);

        // Invalid middle slot skipped: two reads, latency 7
        snap();
        tick();
        enq(6);
        wait_idle("skip_done", 40);
        chk("skip_push_cnt", 32'(push_cnt - s_push), 1);
        chk("skip_var", 32'(last_var), 3);
        chk("skip_vs_reads", 32'(vs_cnt - s_vs), 2);
        chk("skip_latency", 32'(lat), 7);

        // Conflict with two indices queued behind it
        snap();
        tick();
        enq(2);
        enq(1);
        enq(1);
        wait_for("confl_seen", 2, 40);
        chk("confl_busy", 32'(bcp_busy), 0);
        chk("confl_push", 32'(push_cnt - s_push), 0);
        tick();
        enq(1);
        repeat (4) @(negedge clock);
        chk("confl_ignore_ovf", 32'(bcp_overflow), 0);
        chk("confl_busy_hold", 32'(bcp_busy), 0);
        chk("confl_fetches", 32'(cdb_cnt - s_cdb), 1);
        tick();
        pulse_reset_bcp();
        @(negedge clock);
        chk("rbcp_conflict", 32'(conflict), 0);
        repeat (5) @(negedge clock);
        chk("rbcp_flushed", 32'(cdb_cnt - s_cdb), 1);
        chk("rbcp_busy", 32'(bcp_busy), 0);

        // Satisfied clause (first literal true)
        snap();
        tick();
        enq(3);
        wait_idle("sat_done", 40);
        chk("sat_push", 32'(push_cnt - s_push), 0);
`ifdef BCP_EARLY_EXIT_EN
        exp_vs = 1;
`else
        exp_vs = 3;
`endif
        chk("sat_vs_reads", 32'(vs_cnt - s_vs), 32'(exp_vs));
        chk("sat_conflict", 32'(conflict), 0);

        // Empty clause is a conflict with no literal reads
        snap();
        tick();
        enq(5);
        wait_for("empty_conflict", 2, 20);
        chk("empty_vs_reads", 32'(vs_cnt - s_vs), 0);
        tick();
        pulse_reset_bcp();

        // Backpressure: full_imply high for the first five PUSH cycles
        snap();
        full_imply = 1'b1;
        enq(1);
        wait_for("stall_push_seen", 0, 30);
        repeat (5) tick();
        full_imply = 1'b0;
        wait_idle("stall_done", 20);
        chk("stall_held_cycles", 32'(push_hi - s_hi), 6);
        chk("stall_accepted", 32'(push_cnt - s_push), 1);
        chk("stall_stable", 32'(unstable - s_unst), 0);
        chk("stall_var", 32'(last_var), 3);

        // Queue fill while stalled, then overflow on the fifth index
        snap();
        tick();
        full_imply = 1'b1;
        enq(1);
        wait_for("fill_push_seen", 0, 30);
        enq(8);
        enq(9);
        enq(10);
        enq(11);
        @(negedge clock);
        chk("fill_no_overflow", 32'(bcp_overflow), 0);
        enq(12);
        @(negedge clock);
        chk("fill_overflow", 32'(bcp_overflow), 1);
        tick();
        full_imply = 1'b0;
        wait_idle("fill_done", 120);
        chk("fill_fetches", 32'(cdb_cnt - s_cdb), 5);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", 32'(rd_seq[(s_cdb + i) & 63]), 32'(7 + i));
        end
        chk("fill_push", 32'(push_cnt - s_push), 1);
        tick();
        pulse_reset_bcp();
        @(negedge clock);
        chk("fill_ovf_cleared", 32'(bcp_overflow), 0);

        // Asynchronous reset in the middle of a literal read
        tick();
        enq(1);
        enq(6);
        wait_for("ar_rd_seen", 1, 30);
        #1 reset = 1'b0;
        #1;
        chk("ar_read_vs", 32'(read_vs_bcp), 0);
        chk("ar_read_cdb", 32'(read_cdb), 0);
        chk("ar_busy", 32'(bcp_busy), 0);
        chk("ar_push", 32'(push_imply), 0);
        chk("ar_cdb_idx", 32'(cdb_idx), 0);
        chk("ar_var_vs", 32'(var_vs_bcp), 0);
        repeat (2) tick();
        reset = 1'b1;
        snap();
        repeat (5) @(negedge clock);
        chk("ar_queue_empty", 32'(cdb_cnt - s_cdb), 0);
        tick();
        enq(1);
        wait_idle("ar_resume_done", 40);
        chk("ar_resume_push", 32'(push_cnt - s_push), 1);
        chk("ar_resume_var", 32'(last_var), 3);
        chk("ar_resume_latency", 32'(lat), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
